// File: rtl/instr_enc_loader.sv
// Boot/test program loader: packs RV32I field bundles into 32-bit words, buffers them
// in a small FIFO and streams them into instruction memory at consecutive addresses.
module instr_enc_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_count
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int WC_W = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Field-to-word packing for the six RV32I base formats; illegal formats yield zero.
  function automatic logic [31:0] pack_instr(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    case (f)
      3'd0:    w = {f7, s2, s1, f3, d, op};
      3'd1:    w = {im[11:0], s1, f3, d, op};
      3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op};
      3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      3'd4:    w = {im[31:12], d, op};
      3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_waddr;
  logic [WC_W-1:0]   r_wr_count;
  logic              r_err;
  logic              r_done;

  logic              w_full;
  logic              w_empty;
  logic              w_fmt_legal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_done_nxt;
  logic [31:0]       w_packed;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_fmt_legal = (fmt <= 3'd5);
  assign w_packed    = pack_instr(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);

  assign in_ready  = (r_state == S_LOAD) && !w_full;
  assign mem_we    = (r_state != S_IDLE) && !w_empty;
  assign mem_wdata = r_fifo[r_rptr];
  assign mem_waddr = r_waddr;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign wr_count  = r_wr_count;

  // Handshake decode: illegal bundles complete the handshake but are never pushed.
  always_comb begin
    w_accept = in_valid && in_ready;
    w_push   = w_accept && w_fmt_legal;
    w_pop    = mem_we && mem_ready;
  end

  // Next-state logic; done is registered so it pulses in the first idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State, status and write-address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_waddr    <= {ADDR_W{1'b0}};
      r_wr_count <= {WC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == S_IDLE && start) begin
        r_waddr    <= base_addr;
        r_err      <= 1'b0;
        r_wr_count <= {WC_W{1'b0}};
      end else begin
        if (w_accept && !w_fmt_legal) begin
          r_err <= 1'b1;
        end
        if (w_pop) begin
          r_waddr    <= r_waddr + ADDR_W'(1);
          r_wr_count <= r_wr_count + WC_W'(1);
        end
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_packed;
    end
  end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed bench for instr_enc_loader: packing vectors, backpressure, address wrap,
// illegal format handling and reset during drain.
module tb_instr_enc_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic        mem_ready;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] wr_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [41:0] wq[$];

  instr_enc_loader #(.FIFO_DEPTH(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed memory write and every done pulse.
  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready) wq.push_back({mem_waddr, mem_wdata});
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic last);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
    imm = im; in_last = last; in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic last);
    int n = 0;
    drive(f, op, f3, f7, d, s1, s2, im, last);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_session(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=%0b, required 1", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    if (mem_waddr !== 10'h000) begin errors++; $display("FAIL rst_waddr: got %h want 000", mem_waddr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    if (wr_count !== 11'd0) begin errors++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_r_basic();
    wq.delete();
    done_cnt = 0;
    start_session(10'h010);
    drive(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL r_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks += 3;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL r_mem_we_latency: got %0b want 1", mem_we); end
    if (mem_wdata !== 32'h403100B3) begin errors++; $display("FAIL r_wdata: got %h want 403100B3", mem_wdata); end
    if (mem_waddr !== 10'h010) begin errors++; $display("FAIL r_waddr: got %h want 010", mem_waddr); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL r_done_early: got %0b want 0", done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL r_busy_drain: got %0b want 1", busy); end
    @(negedge clk);
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL r_done_pulse: got %0b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL r_busy_idle: got %0b want 0", busy); end
    if (wr_count !== 11'd1) begin errors++; $display("FAIL r_wr_count: got %0d want 1", wr_count); end
    if (wq.size() != 1) begin errors++; $display("FAIL r_nwrites: got %0d want 1", wq.size()); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL r_done_width: got %0b want 0", done); end
    if (done_cnt != 1) begin errors++; $display("FAIL r_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_formats();
    logic [31:0] exp_w [5] = '{32'hFFF00293, 32'hFE208EE3, 32'h123450B7, 32'h001000EF, 32'h00512423};
    wq.delete();
    start_session(10'h100);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0);
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h00000008, 1'b1);
    wait_done();
    checks += 3;
    if (wq.size() != 5) begin errors++; $display("FAIL fmt_nwrites: got %0d want 5", wq.size()); end
    if (err !== 1'b0) begin errors++; $display("FAIL fmt_err: got %0b want 0", err); end
    if (wr_count !== 11'd5) begin errors++; $display("FAIL fmt_wr_count: got %0d want 5", wr_count); end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {10'h100 + 10'(i), exp_w[i]}) begin
        errors++;
        $display("FAIL fmt_word%0d: got %h/%h want %h/%h", i, wq[i][41:32], wq[i][31:0], 10'h100 + 10'(i), exp_w[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [6] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
    int k = 0;
    logic v;
    wq.delete();
    mem_ready = 1'b0;
    start_session(10'h020);
    for (int c = 0; c < 10; c++) begin
      drive(3'd1, 7'h13, 3'd0, 7'h00, 5'(k), 5'd0, 5'd0, 32'(k), 1'b0);
      v = in_ready;
      @(negedge clk);
      if (v) k++;
    end
    in_valid = 1'b0;
    checks += 4;
    if (k != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", k); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    if (mem_we !== 1'b1) begin errors++; $display("FAIL bp_mem_we: got %0b want 1", mem_we); end
    if (mem_wdata !== 32'h00000013) begin errors++; $display("FAIL bp_head: got %h want 00000013", mem_wdata); end
    mem_ready = 1'b1;
    for (int j = k; j < 6; j++) begin
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'(j), 5'd0, 5'd0, 32'(j), (j == 5));
    end
    wait_done();
    checks += 2;
    if (wq.size() != 6) begin errors++; $display("FAIL bp_nwrites: got %0d want 6", wq.size()); end
    if (wr_count !== 11'd6) begin errors++; $display("FAIL bp_wr_count: got %0d want 6", wr_count); end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {10'h020 + 10'(i), exp_w[i]}) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%h want %h/%h", i, wq[i][41:32], wq[i][31:0], 10'h020 + 10'(i), exp_w[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [9:0]  exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [31:0] exp_w [4] = '{32'h000010B7, 32'h00002137, 32'h000031B7, 32'h00004237};
    wq.delete();
    start_session(10'h3FE);
    for (int j = 1; j <= 4; j++) begin
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'(j), 5'd0, 5'd0, 32'(j) << 12, (j == 4));
    end
    wait_done();
    checks += 3;
    if (wq.size() != 4) begin errors++; $display("FAIL wrap_nwrites: got %0d want 4", wq.size()); end
    if (wr_count !== 11'd4) begin errors++; $display("FAIL wrap_wr_count: got %0d want 4", wr_count); end
    if (mem_waddr !== 10'h002) begin errors++; $display("FAIL wrap_final_addr: got %h want 002", mem_waddr); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {exp_a[i], exp_w[i]}) begin
        errors++;
        $display("FAIL wrap_word%0d: got %h/%h want %h/%h", i, wq[i][41:32], wq[i][31:0], exp_a[i], exp_w[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    wq.delete();
    start_session(10'h040);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    send(3'd7, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1);
    wait_done();
    checks += 5;
    if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %0b want 1", err); end
    if (wq.size() != 2) begin errors++; $display("FAIL ill_nwrites: got %0d want 2", wq.size()); end
    if (wr_count !== 11'd2) begin errors++; $display("FAIL ill_wr_count: got %0d want 2", wr_count); end
    if (wq.size() > 0 && wq[0] !== {10'h040, 32'h00100093}) begin
      errors++; $display("FAIL ill_word0: got %h want 04000100093", wq[0]);
    end
    if (wq.size() > 1 && wq[1] !== {10'h041, 32'h00300193}) begin
      errors++; $display("FAIL ill_word1: got %h want 04100300193", wq[1]);
    end
    @(negedge clk);
    start_session(10'h060);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear: got %0b want 0", err); end
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    wq.delete();
    done_cnt = 0;
    mem_ready = 1'b0;
    start_session(10'h050);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_pre: got %0b want 1", busy); end
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rd_mem_we_pre: got %0b want 1", mem_we); end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %0b want 0", mem_we); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy: got %0b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rd_in_ready: got %0b want 0", in_ready); end
    if (wr_count !== 11'd0) begin errors++; $display("FAIL rd_wr_count: got %0d want 0", wr_count); end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks += 3;
    if (wq.size() != 0) begin errors++; $display("FAIL rd_writes_after: got %0d want 0", wq.size()); end
    if (done_cnt != 0) begin errors++; $display("FAIL rd_done: got %0d want 0", done_cnt); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we_after: got %0b want 0", mem_we); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 10'h000; in_valid = 1'b0; in_last = 1'b0;
    fmt = 3'd0; opcode = 7'h00; funct3 = 3'd0; funct7 = 7'h00; rd = 5'd0; rs1 = 5'd0;
    rs2 = 5'd0; imm = 32'h0; mem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_r_basic();
    test_formats();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
